// File: rtl/instr_mem_loader_pkg.sv
// Shared constants for the instruction-memory loader: memory geometry, image byte order,
// and FSM state encodings.
package instr_mem_loader_pkg;

  localparam int unsigned IMEM_ADDR_W = 8;
  localparam int unsigned IMEM_DATA_W = 16;

  // Image words arrive high byte first (big-endian).
  localparam bit IMG_HI_BYTE_FIRST = 1'b1;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t StIdle = 3'd0;
  localparam loader_state_t StLen  = 3'd1;
  localparam loader_state_t StHi   = 3'd2;
  localparam loader_state_t StLo   = 3'd3;
  localparam loader_state_t StChk  = 3'd4;
  localparam loader_state_t StDone = 3'd5;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The master modport is the loader side; slave is the stream source / memory side.
interface instr_mem_loader_if
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W
);
  logic [7:0]             byte_in;
  logic                   byte_valid;
  logic                   byte_ready;
  logic                   mem_wr_en;
  logic [ADDR_W-1:0]      mem_wr_addr;
  logic [IMEM_DATA_W-1:0] mem_wr_data;

  modport master (
    input  byte_in, byte_valid,
    output byte_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed big-endian program image into the instruction memory.
// Define CHECKSUM_EN to expect and verify a trailing XOR checksum byte.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned LEN_W  = ADDR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  instr_mem_loader_if.master bus,
  output logic [LEN_W-1:0]   prog_len,
  output logic               load_busy,
  output logic               load_done,
  output logic               load_error
);

  loader_state_t          state_q, state_d;
  logic [ADDR_W-1:0]      len_q, len_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [7:0]             hi_q, hi_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [IMEM_DATA_W-1:0] wr_data_q, wr_data_d;
  logic [LEN_W-1:0]       prog_len_q, prog_len_d;
  logic                   err_q, err_d;
  logic                   xfer;

  assign load_busy = (state_q == StLen) || (state_q == StHi) ||
                     (state_q == StLo)  || (state_q == StChk);
  assign load_done = (state_q == StDone);
  assign xfer      = bus.byte_valid && load_busy;

  assign bus.byte_ready  = load_busy;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_addr = wr_addr_q;
  assign bus.mem_wr_data = wr_data_q;
  assign prog_len        = prog_len_q;

`ifdef CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  // Running XOR seeded by the length byte, then folded with every data byte.
  always_comb begin
    csum_d = csum_q;
    if (xfer && (state_q == StLen)) begin
      csum_d = bus.byte_in;
    end else if (xfer && ((state_q == StHi) || (state_q == StLo))) begin
      csum_d = csum_q ^ bus.byte_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign load_error = err_q;
`else
  assign load_error = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    hi_d       = hi_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    prog_len_d = prog_len_q;
    err_d      = err_q;
    case (state_q)
      StIdle: if (start) begin
        prog_len_d = '0;
        err_d      = 1'b0;
        state_d    = StLen;
      end
      StLen: if (xfer) begin
        len_d   = ADDR_W'(bus.byte_in);
        idx_d   = '0;
        state_d = StHi;
      end
      StHi: if (xfer) begin
        hi_d    = bus.byte_in;
        state_d = StLo;
      end
      StLo: if (xfer) begin
        wr_en_d    = 1'b1;
        wr_addr_d  = idx_q;
        wr_data_d  = IMG_HI_BYTE_FIRST ? {hi_q, bus.byte_in} : {bus.byte_in, hi_q};
        prog_len_d = prog_len_q + LEN_W'(1);
        // Index saturates at L so a full 2**ADDR_W image never wraps.
        if (idx_q == len_q) begin
`ifdef CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StDone;
`endif
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = StHi;
        end
      end
`ifdef CHECKSUM_EN
      StChk: if (xfer) begin
        err_d   = (bus.byte_in != csum_q);
        state_d = StDone;
      end
`endif
      StDone: if (start) begin
        prog_len_d = '0;
        err_d      = 1'b0;
        state_d    = StLen;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      idx_q      <= '0;
      hi_q       <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      prog_len_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      hi_q       <= hi_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      prog_len_q <= prog_len_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table-driven images, randomized images against a
// word-list reference model, and hand-written reset/start corner sequences.
module tb_instr_mem_loader;
  import instr_mem_loader_pkg::*;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LEN_W  = ADDR_W + 1;
`ifdef CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] prog_len;
  logic             load_busy, load_done, load_error;

  instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_mem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .prog_len  (prog_len),
    .load_busy (load_busy),
    .load_done (load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] plen;
    logic [31:0] done;
  } wr_t;
  wr_t wrs[$];

  // Observed write strobes, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_wr_en === 1'b1) begin
      wrs.push_back('{32'(bus.mem_wr_addr), 32'(bus.mem_wr_data), 32'(prog_len),
                      32'(load_done)});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void build_img(input logic [15:0] words[$], input bit bad_csum,
                                    output logic [7:0] img[$]);
    logic [7:0] x;
    img = {};
    img.push_back(8'(words.size() - 1));
    x = 8'(words.size() - 1);
    foreach (words[i]) begin
      img.push_back(words[i][15:8]);
      img.push_back(words[i][7:0]);
      x = x ^ words[i][15:8] ^ words[i][7:0];
    end
    if (CSUM) img.push_back(bad_csum ? ((x == 8'h00) ? 8'hFF : 8'h00) : x);
  endfunction

  // Called at a negedge; returns at a negedge. gap < 0 toggles valid every other cycle.
  task automatic feed(input logic [7:0] img[$], input int gap, input int start_at);
    int  i;
    int  cyc;
    bit  v;
    bit  rdy;
    i   = 0;
    cyc = 0;
    while (i < img.size()) begin
      v = (gap < 0) ? (cyc % 2 == 0) : ($urandom_range(99) >= gap);
      bus.byte_valid = v;
      bus.byte_in    = v ? img[i] : 8'($urandom);
      start          = (i == start_at);
      rdy            = bus.byte_ready;
      @(posedge clk);
      if (v && rdy) i++;
      @(negedge clk);
      cyc++;
      if (cyc > 5000) begin
        check("feed_timeout", 32'(i), 32'(img.size()));
        break;
      end
    end
    bus.byte_valid = 1'b0;
    start          = 1'b0;
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reference model: image words land at addresses 0..n-1 in order, one strobe each.
  task automatic run_image(input string tag, input logic [15:0] words[$], input int gap,
                           input int start_at, input bit do_start, input bit bad_csum);
    logic [7:0] img[$];
    int         n;
    n = words.size();
    build_img(words, bad_csum, img);
    wrs.delete();
    if (do_start) pulse_start();
    feed(img, gap, start_at);
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_nwr"}, 32'(wrs.size()), 32'(n));
    for (int i = 0; i < n && i < wrs.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wrs[i].addr, 32'(i));
      check($sformatf("%s_data%0d", tag, i), wrs[i].data, 32'(words[i]));
      check($sformatf("%s_plen%0d", tag, i), wrs[i].plen, 32'(i + 1));
      check($sformatf("%s_done%0d", tag, i), wrs[i].done, 32'((i == n - 1) && !CSUM));
    end
    check({tag, "_prog_len"}, 32'(prog_len), 32'(n));
    check({tag, "_done"}, 32'(load_done), 32'd1);
    check({tag, "_busy"}, 32'(load_busy), 32'd0);
    check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_error"}, 32'(load_error), 32'(CSUM && bad_csum));
  endtask

  typedef struct {
    int          n;
    logic [15:0] base;
    logic [15:0] step;
    int          gap;
    int          start_at;
    logic [31:0] exp_len;
    logic [31:0] exp_last_addr;
    logic [31:0] exp_last_data;
  } vec_t;

  initial begin
    vec_t        vecs[4];
    logic [15:0] words[$];
    logic [7:0]  img[$];

    vecs[0] = '{1,   16'h1234, 16'h0000,  0, -1, 32'd1,   32'h00, 32'h1234};
    vecs[1] = '{3,   16'hAAAA, 16'h1111, -1, -1, 32'd3,   32'h02, 32'hCCCC};
    vecs[2] = '{256, 16'h0000, 16'h0001,  0, -1, 32'd256, 32'hFF, 32'h00FF};
    vecs[3] = '{8,   16'h8000, 16'h0101, 30,  1, 32'd8,   32'h07, 32'h8707};

    rst_n          = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    #12;
    check("rst_prog_len", 32'(prog_len), 32'd0);
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_error", 32'(load_error), 32'd0);
    check("rst_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.mem_wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.mem_wr_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus.byte_ready), 32'd0);

    foreach (vecs[k]) begin
      words = {};
      for (int i = 0; i < vecs[k].n; i++) words.push_back(vecs[k].base + 16'(i) * vecs[k].step);
      run_image($sformatf("vec%0d", k), words, vecs[k].gap, vecs[k].start_at, 1'b1, 1'b0);
      check($sformatf("vec%0d_len", k), 32'(prog_len), vecs[k].exp_len);
      if (wrs.size() > 0) begin
        check($sformatf("vec%0d_last_addr", k), wrs[wrs.size()-1].addr, vecs[k].exp_last_addr);
        check($sformatf("vec%0d_last_data", k), wrs[wrs.size()-1].data, vecs[k].exp_last_data);
      end
    end

    // Start in DONE together with a valid byte: start wins, the byte is dropped.
    @(negedge clk);
    start          = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h55;
    @(negedge clk);
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    check("restart_done", 32'(load_done), 32'd0);
    check("restart_busy", 32'(load_busy), 32'd1);
    check("restart_prog_len", 32'(prog_len), 32'd0);
    words = '{16'h5A5A};
    run_image("restart", words, 0, -1, 1'b0, 1'b0);

    // Reset after three words of a five-word load.
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    build_img(words, 1'b0, img);
    img = img[0:6];
    wrs.delete();
    pulse_start();
    feed(img, 0, -1);
    check("midrst_wr_en_pre", 32'(bus.mem_wr_en), 32'd1);
    check("midrst_prog_len_pre", 32'(prog_len), 32'd3);
    rst_n = 1'b0;
    #1;
    check("midrst_prog_len", 32'(prog_len), 32'd0);
    check("midrst_busy", 32'(load_busy), 32'd0);
    check("midrst_ready", 32'(bus.byte_ready), 32'd0);
    check("midrst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("midrst_done", 32'(load_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle_ready", 32'(bus.byte_ready), 32'd0);
    words = '{16'hBEEF};
    run_image("postrst", words, 0, -1, 1'b1, 1'b0);

`ifdef CHECKSUM_EN
    words = '{16'h1234, 16'h5678};
    run_image("csum_good", words, 0, -1, 1'b1, 1'b0);
    run_image("csum_bad", words, 0, -1, 1'b1, 1'b1);
    run_image("csum_clear", words, 20, -1, 1'b1, 1'b0);
`endif

    for (int r = 0; r < 6; r++) begin
      int n;
      n = (r == 5) ? int'($urandom_range(100, 200)) : int'($urandom_range(1, 24));
      words = {};
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
      run_image($sformatf("rnd%0d", r), words, int'($urandom_range(0, 60)), -1, 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
